// File: rtl/uart_trans_cfg.sv
// UART transmitter with run-time frame format (5-8 data bits, optional parity, 1/2 stop bits),
// ready/busy handshake, FIFO read strobe, end-of-frame pulse and mid-frame abort.
//
// state  | meaning
// IDLE   | line high, ready to accept a character
// START  | start bit (tx=0) for one bit period
// DATA   | shifting out len data bits, LSB first
// PARITY | optional parity bit for one bit period
// STOP   | one or two stop bits (tx=1), done pulse at the end
module uart_trans_cfg #(
  parameter int MAX_DATA_BITS = 8,
  parameter int OVERSAMPLE    = 16
) (
  input  logic                     clk,
  input  logic                     resetN,
  input  logic                     sTick,
  input  logic                     txStart,
  input  logic [MAX_DATA_BITS-1:0] din,
  input  logic [1:0]               lenSel,
  input  logic                     parityEn,
  input  logic                     parityOdd,
  input  logic                     stop2,
  input  logic                     txAbort,
  output logic                     tx,
  output logic                     txReady,
  output logic                     rdTick,
  output logic                     txDoneTick
);

  localparam int         NW     = $clog2(MAX_DATA_BITS);
  localparam logic [3:0] S_LAST = 4'(OVERSAMPLE - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                   state, state_d;
  logic [3:0]               s_cnt, s_cnt_d;
  logic [NW-1:0]            n_cnt, n_cnt_d, len_m1, len_m1_d, len_sel_m1;
  logic [MAX_DATA_BITS-1:0] shift, shift_d, din_mask;
  logic                     par_en, par_en_d, par_bit, par_bit_d;
  logic                     two_stop, two_stop_d, stop_idx, stop_idx_d;
  logic                     tx_q, tx_d, bit_end;

  assign len_sel_m1 = NW'(lenSel) + NW'(4);
  assign bit_end    = sTick && (s_cnt == S_LAST);
  assign tx         = tx_q;
  assign txReady    = (state == IDLE);

  always_comb begin
    din_mask = '0;
    for (int i = 0; i < MAX_DATA_BITS; i++) din_mask[i] = (i <= int'(len_sel_m1));
  end

  always_comb begin
    state_d    = state;
    s_cnt_d    = s_cnt;
    n_cnt_d    = n_cnt;
    shift_d    = shift;
    len_m1_d   = len_m1;
    par_en_d   = par_en;
    par_bit_d  = par_bit;
    two_stop_d = two_stop;
    stop_idx_d = stop_idx;
    rdTick     = 1'b0;
    txDoneTick = 1'b0;
    if (state != IDLE && sTick) s_cnt_d = bit_end ? 4'd0 : s_cnt + 4'd1;
    case (state)
      IDLE: if (txStart && !txAbort) begin
        rdTick     = 1'b1;
        state_d    = START;
        shift_d    = din;
        len_m1_d   = len_sel_m1;
        par_en_d   = parityEn;
        // parity is fixed at accept so later config changes cannot disturb it
        par_bit_d  = (^(din & din_mask)) ^ parityOdd;
        two_stop_d = stop2;
        s_cnt_d    = '0;
        n_cnt_d    = '0;
        stop_idx_d = 1'b0;
      end
      START: if (bit_end) begin
        state_d = DATA;
        n_cnt_d = '0;
      end
      DATA: if (bit_end) begin
        shift_d = shift >> 1;
        if (n_cnt == len_m1) state_d = par_en ? PARITY : STOP;
        else                 n_cnt_d = n_cnt + NW'(1);
      end
      PARITY: if (bit_end) begin
        state_d    = STOP;
        stop_idx_d = 1'b0;
      end
      STOP: if (bit_end) begin
        if (two_stop && !stop_idx) stop_idx_d = 1'b1;
        else begin
          txDoneTick = 1'b1;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (txAbort && state != IDLE) begin
      state_d    = IDLE;
      s_cnt_d    = '0;
      n_cnt_d    = '0;
      stop_idx_d = 1'b0;
      txDoneTick = 1'b0;
    end
    // tx is registered from the next state, giving one clock of latency after accept
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = par_bit;
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state    <= IDLE;
      s_cnt    <= '0;
      n_cnt    <= '0;
      shift    <= '0;
      len_m1   <= '0;
      par_en   <= 1'b0;
      par_bit  <= 1'b0;
      two_stop <= 1'b0;
      stop_idx <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state    <= state_d;
      s_cnt    <= s_cnt_d;
      n_cnt    <= n_cnt_d;
      shift    <= shift_d;
      len_m1   <= len_m1_d;
      par_en   <= par_en_d;
      par_bit  <= par_bit_d;
      two_stop <= two_stop_d;
      stop_idx <= stop_idx_d;
      tx_q     <= tx_d;
    end
  end

endmodule
